// File: rtl/data_memory_line.sv
// Line-granular backing memory behind the data cache: one 256-bit line read or
// write per request, fixed latency, one-cycle ack followed by a dead GAP cycle.
module data_memory_line #(
  parameter int MEM_LATENCY = 10,
  parameter int DEPTH_LOG2  = 10,
  parameter int LINE_W      = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [CNT_W-1:0]        count_r;
  logic                    write_r;
  logic [DEPTH_LOG2-1:0]   line_r;
  logic [LINE_W-1:0]       wdata_r;
  logic                    commit_s;
  logic [LINE_W-1:0]       mem_r [2**DEPTH_LOG2];

  // Offset bits and high (aliasing) address bits never select anything.
  logic unused_addr_s;
  assign unused_addr_s = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

  assign commit_s = (state_r == BUSY) && (count_r == LAST);

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable_i) state_s = BUSY;
        else          state_s = IDLE;
      end
      BUSY: begin
        if (commit_s) state_s = ACK;
        else          state_s = BUSY;
      end
      ACK:     state_s = GAP;
      GAP:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latency counter, request latch, ack and read-data registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      ack_o   <= 1'b0;
      data_o  <= '0;
      count_r <= '0;
      write_r <= 1'b0;
      line_r  <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_s;
      ack_o   <= (state_s == ACK);
      if (state_r == IDLE && enable_i) begin
        write_r <= write_i;
        line_r  <= addr_i[DEPTH_LOG2+4:5];
        wdata_r <= data_i;
        count_r <= CNT_W'(1);
      end else if (state_r == BUSY) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
      if (commit_s && !write_r) begin
        data_o <= mem_r[line_r];
      end
    end
  end

  // Line array: contents survive reset, but a reset edge blocks the commit.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit_s && write_r) begin
      mem_r[line_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_data_memory_line.sv
// Directed bench for data_memory_line: latency, offset/alias addressing,
// writeback-then-refill handshake, back-to-back reads, reset abort.
module tb_data_memory_line;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         wr;
  logic [31:0]  addr;
  logic [255:0] din;
  logic         ack;
  logic [255:0] dout;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  data_memory_line dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (en),
    .write_i  (wr),
    .addr_i   (addr),
    .data_i   (din),
    .ack_o    (ack),
    .data_o   (dout)
  );

  localparam logic [255:0] VAL_A = {8{32'hDEADBEEF}};
  localparam logic [255:0] VAL_P = {8{32'h0BADF00D}};
  localparam logic [255:0] VAL_Q = {8{32'h12345678}};
  localparam logic [255:0] VAL_R = {8{32'hA5A5_5A5A}};
  localparam logic [255:0] VAL_B = {8{32'hFFFF_0000}};
  localparam logic [255:0] VAL_C = {8{32'h1111_2222}};
  localparam logic [255:0] VAL_D = {8{32'h3333_4444}};
  localparam logic [255:0] VAL_E = {8{32'hCAFE_BABE}};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one request from IDLE; data_i/write_i/addr_i are scrambled right
  // after acceptance. Ends in the GAP cycle, so the next call starts in IDLE.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [255:0] d, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    en = 1'b1; wr = w; addr = a; din = d;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        en = 1'b0; wr = ~w; addr = ~a; din = ~d;
      end
      if (ack) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, 256'(lat), 256'd10);
    @(negedge clk);
    check({tag, " ack one cycle"}, 256'(ack), 256'd0);
  endtask

  initial begin
    int acks;
    int first_c;
    int second_c;
    int consec;
    int ack_seen;
    int ack_cyc [3];
    logic prev_ack;
    logic [255:0] d2;

    rst = 1'b0; en = 1'b0; wr = 1'b0; addr = 32'h0; din = '0;
    repeat (3) @(negedge clk);
    check("reset ack", 256'(ack), 256'd0);
    check("reset data", dout, 256'd0);
    rst = 1'b1;

    // basic write/read, then offset bits ignored
    do_req(1'b1, 32'h20, VAL_A, "t1 write");
    do_req(1'b0, 32'h20, '0, "t1 read");
    check("t1 data", dout, VAL_A);
    do_req(1'b0, 32'h3F, '0, "t2 read");
    check("t2 offset", dout, VAL_A);

    // writeback-then-refill with enable held
    do_req(1'b1, 32'h800, VAL_P, "t3 preload");
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h400; din = VAL_Q;
    acks = 0; first_c = 0; second_c = 0; d2 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (first_c != 0 && c == first_c + 1) begin
        wr = 1'b0; addr = 32'h800; din = VAL_R;
      end
      if (second_c != 0 && c == second_c + 2) en = 1'b0;
      if (ack) begin
        acks++;
        if (acks == 1) first_c = c;
        else if (acks == 2) begin
          second_c = c;
          d2 = dout;
        end
      end
    end
    check("t3 ack count", 256'(acks), 256'd2);
    check("t3 first ack", 256'(first_c), 256'd10);
    check("t3 second ack", 256'(second_c), 256'd22);
    check("t3 refill data", d2, VAL_P);
    do_req(1'b0, 32'h400, '0, "t3 readback");
    check("t3 written line", dout, VAL_Q);

    // continuous read requests
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = 32'h800;
    acks = 0; consec = 0; prev_ack = 1'b0;
    for (int i = 0; i < 3; i++) ack_cyc[i] = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ack && prev_ack) consec++;
      if (ack) begin
        if (acks < 3) ack_cyc[acks] = c;
        acks++;
      end
      prev_ack = ack;
    end
    en = 1'b0;
    check("t4 ack count", 256'(acks), 256'd3);
    check("t4 ack0", 256'(ack_cyc[0]), 256'd10);
    check("t4 ack1", 256'(ack_cyc[1]), 256'd22);
    check("t4 ack2", 256'(ack_cyc[2]), 256'd34);
    check("t4 consecutive", 256'(consec), 256'd0);
    check("t4 data", dout, VAL_P);
    repeat (15) @(negedge clk);

    // reset during a write aborts it
    do_req(1'b1, 32'h100, VAL_A, "t5 write A");
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr = 32'h100; din = VAL_B;
    @(posedge clk);
    ack_seen = 0;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) en = 1'b0;
      if (ack) ack_seen++;
      if (n == 5) rst = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    check("t5 reset ack", 256'(ack), 256'd0);
    check("t5 reset data", dout, 256'd0);
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (ack) ack_seen++;
    end
    check("t5 no ack", 256'(ack_seen), 256'd0);
    do_req(1'b0, 32'h100, '0, "t5 read");
    check("t5 old data", dout, VAL_A);

    // aliasing and data_i sampled only at acceptance
    do_req(1'b1, 32'h0, VAL_C, "t6 write 0");
    do_req(1'b1, 32'h8000, VAL_D, "t6 write 8000");
    do_req(1'b0, 32'h0, '0, "t6 read 0");
    check("t6 alias", dout, VAL_D);
    do_req(1'b1, 32'h40, VAL_E, "t6 write 40");
    do_req(1'b0, 32'h40, '0, "t6 read 40");
    check("t6 sampled data", dout, VAL_E);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
